// File: rtl/bird_motion_ctrl.sv
// bird_motion_ctrl: bird row sequencing, IDLE/PLAY/DEAD game flow and score keeping
module bird_motion_ctrl #(
  parameter int ROWS       = 16,
  parameter int START_ROW  = 8,
  parameter int FALL_TICKS = 2,
  parameter int RISE_STEPS = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flap,
  input  logic                    tick,
  input  logic                    collide,
  input  logic                    pass,
  output logic [$clog2(ROWS)-1:0] bird_row,
  output logic [ROWS-1:0]         bird_onehot,
  output logic                    playing,
  output logic                    game_over,
  output logic [7:0]              score
);
  localparam int RW = $clog2(ROWS);
  localparam int FW = $clog2(FALL_TICKS + 1);
  localparam int PW = $clog2(RISE_STEPS + 1);
  localparam logic [RW-1:0] ROW_START = RW'(START_ROW);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
  localparam logic [FW-1:0] FALL_LAST = FW'(FALL_TICKS - 1);
  localparam logic [PW-1:0] RISE_LOAD = PW'(RISE_STEPS);
  typedef enum logic [1:0] {IDLE, PLAY, DEAD} state_t;
  state_t state, state_n;
  logic [RW-1:0] row_n;
  logic [7:0] score_n;
  logic [FW-1:0] fall_cnt, fall_n, fall_v;
  logic [PW-1:0] rise_pend, rise_n, rise_v;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= IDLE;
      bird_row  <= ROW_START;
      score     <= '0;
      fall_cnt  <= '0;
      rise_pend <= '0;
    end else begin
      state     <= state_n;
      bird_row  <= row_n;
      score     <= score_n;
      fall_cnt  <= fall_n;
      rise_pend <= rise_n;
    end
  // a flap is applied before the tick so that flap+tick in one cycle rises at once
  always_comb begin
    state_n = state;
    row_n   = bird_row;
    score_n = score;
    fall_n  = fall_cnt;
    rise_n  = rise_pend;
    rise_v  = flap ? RISE_LOAD : rise_pend;
    fall_v  = flap ? '0 : fall_cnt;
    case (state)
      IDLE: if (flap) begin
        state_n = PLAY;
        score_n = '0;
        fall_n  = '0;
        rise_n  = '0;
      end
      PLAY: if (collide) state_n = DEAD;
      else begin
        rise_n = rise_v;
        fall_n = fall_v;
        if (tick && |rise_v) begin
          row_n  = bird_row == '0 ? '0 : bird_row - 1'b1;
          rise_n = rise_v - 1'b1;
        end else if (tick && fall_v == FALL_LAST) begin
          fall_n  = '0;
          state_n = bird_row == ROW_LAST ? DEAD : PLAY;
          row_n   = bird_row == ROW_LAST ? bird_row : bird_row + 1'b1;
        end else if (tick) fall_n = fall_v + 1'b1;
        if (pass && score != 8'hff) score_n = score + 1'b1;
      end
      DEAD: if (flap) begin
        state_n = IDLE;
        row_n   = ROW_START;
        fall_n  = '0;
        rise_n  = '0;
      end
      default: state_n = IDLE;
    endcase
  end
  assign bird_onehot = {{(ROWS-1){1'b0}}, 1'b1} << bird_row;
  assign playing     = state == PLAY;
  assign game_over   = state == DEAD;
endmodule
